// File: rtl/ps2_hostport.sv
// PS/2 host port: filtered receive path that folds E0/F0 prefixes into a
// first-word-fall-through FIFO, plus a host-to-device transmitter with inhibit/request/ack.
module ps2_hostport #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 8,
  parameter int INHIBIT_CYC = 2800,
  parameter int TIMEOUT_CYC = 56000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe,
  output logic [7:0] rx_data,
  output logic       rx_extended,
  output logic       rx_released,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_err,
  output logic       rx_overflow,
  input  logic       rx_ovf_clr,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + INHIBIT_CYC + 2);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_ACK     = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q, clk_f_q, fall_q;
  logic [FW-1:0] fcnt_q;

  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic          rx_par_q, rx_par_d;
  logic [TW-1:0] rx_gap_q, rx_gap_d;
  logic          ext_q, ext_d, rel_q, rel_d;
  logic          push_q, push_d, rx_err_q, rx_err_d;
  logic [9:0]    push_word_q, push_word_d;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, pop_s, full_s, wr_en_s;

  logic [2:0]    tx_st_q, tx_st_d;
  logic [TW-1:0] tx_tmr_q, tx_tmr_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_sr_q, tx_sr_d;
  logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic          tx_done_q, tx_done_d, tx_error_q, tx_error_d, tx_busy_q;
  logic          tx_to_s;

  // Synchronise both pins; a clock level is accepted after FILTER_LEN equal samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      clk_f_q  <= 1'b1;
      fcnt_q   <= FW'(0);
      fall_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2clk_in;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2dat_in;
      dat_s2_q <= dat_s1_q;
      fall_q   <= 1'b0;
      if (clk_s2_q != clk_f_q) begin
        if (fcnt_q == FW'(FILTER_LEN - 1)) begin
          clk_f_q <= clk_s2_q;
          fcnt_q  <= FW'(0);
          fall_q  <= clk_f_q;
        end else begin
          fcnt_q <= fcnt_q + FW'(1);
        end
      end else begin
        fcnt_q <= FW'(0);
      end
    end
  end

  // Receive frame decode; prefixes only update flags, other bytes are queued
  always_comb begin
    rx_bit_d    = rx_bit_q;
    rx_sr_d     = rx_sr_q;
    rx_par_d    = rx_par_q;
    rx_gap_d    = rx_gap_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    rx_err_d    = 1'b0;
    if ((tx_st_q != S_IDLE) || tx_load) begin
      rx_bit_d = 4'd0;
      rx_gap_d = TW'(0);
    end else if (fall_q) begin
      rx_gap_d = TW'(0);
      case (rx_bit_q)
        4'd0: begin
          if (!dat_s2_q) rx_bit_d = 4'd1;
          else           rx_bit_d = 4'd0;
        end
        4'd9: begin
          rx_par_d = dat_s2_q;
          rx_bit_d = 4'd10;
        end
        4'd10: begin
          rx_bit_d = 4'd0;
          if (dat_s2_q && (^{rx_sr_q, rx_par_q})) begin
            if (rx_sr_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (rx_sr_q == 8'hF0) begin
              rel_d = 1'b1;
            end else begin
              push_d      = 1'b1;
              push_word_d = {ext_q, rel_q, rx_sr_q};
              ext_d       = 1'b0;
              rel_d       = 1'b0;
            end
          end else begin
            rx_err_d = 1'b1;
          end
        end
        default: begin
          rx_sr_d  = {dat_s2_q, rx_sr_q[7:1]};
          rx_bit_d = rx_bit_q + 4'd1;
        end
      endcase
    end else if (rx_bit_q != 4'd0) begin
      if (rx_gap_q == TW'(TIMEOUT_CYC)) begin
        rx_bit_d = 4'd0;
        rx_gap_d = TW'(0);
        rx_err_d = 1'b1;
      end else begin
        rx_gap_d = rx_gap_q + TW'(1);
      end
    end else begin
      rx_gap_d = TW'(0);
    end
  end

  // Receive state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_bit_q    <= 4'd0;
      rx_sr_q     <= 8'h00;
      rx_par_q    <= 1'b0;
      rx_gap_q    <= TW'(0);
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= 10'h000;
      rx_err_q    <= 1'b0;
    end else begin
      rx_bit_q    <= rx_bit_d;
      rx_sr_q     <= rx_sr_d;
      rx_par_q    <= rx_par_d;
      rx_gap_q    <= rx_gap_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      rx_err_q    <= rx_err_d;
    end
  end

  // FIFO control: a push on a full FIFO only survives if a pop frees a slot that cycle
  always_comb begin
    pop_s   = (cnt_q != CW'(0)) && rx_ready;
    full_s  = (cnt_q == CW'(FIFO_DEPTH));
    wr_en_s = push_q && (!full_s || pop_s);
    case ({wr_en_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push_q && full_s && !pop_s) ovf_d = 1'b1;
    else if (rx_ovf_clr)            ovf_d = 1'b0;
    else                            ovf_d = ovf_q;
  end

  // FIFO pointers and storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= PW'(0);
      rd_q  <= PW'(0);
      cnt_q <= CW'(0);
      ovf_q <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_q] <= push_word_q;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_s) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign tx_to_s = (tx_tmr_q == TW'(TIMEOUT_CYC));

  // Transmit handshake; all line drives are computed here and registered
  always_comb begin
    tx_st_d    = tx_st_q;
    tx_tmr_d   = tx_tmr_q;
    tx_bit_d   = tx_bit_q;
    tx_sr_d    = tx_sr_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    tx_done_d  = 1'b0;
    tx_error_d = 1'b0;
    case (tx_st_q)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_load) begin
          tx_st_d  = S_INHIBIT;
          tx_sr_d  = {~^tx_data, tx_data};
          tx_tmr_d = TW'(0);
          clk_oe_d = 1'b1;
        end else begin
          tx_tmr_d = TW'(0);
        end
      end
      S_INHIBIT: begin
        if (tx_tmr_q == TW'(INHIBIT_CYC - 1)) begin
          tx_st_d  = S_REQ;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          tx_tmr_d = TW'(0);
          tx_bit_d = 4'd0;
        end else begin
          tx_tmr_d = tx_tmr_q + TW'(1);
        end
      end
      S_REQ, S_ACK, S_WAIT: begin
        if ((tx_st_q == S_WAIT) && clk_f_q && dat_s2_q) begin
          tx_st_d  = S_IDLE;
          tx_tmr_d = TW'(0);
        end else if (fall_q && (tx_st_q != S_WAIT)) begin
          tx_tmr_d = TW'(0);
          if (tx_st_q == S_ACK) begin
            tx_done_d  = !dat_s2_q;
            tx_error_d = dat_s2_q;
            tx_st_d    = S_WAIT;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            if (tx_bit_q < 4'd8) begin
              dat_oe_d = ~tx_sr_q[tx_bit_q[2:0]];
            end else if (tx_bit_q == 4'd8) begin
              dat_oe_d = ~tx_sr_q[8];
            end else begin
              dat_oe_d = 1'b0;
              tx_st_d  = S_ACK;
            end
          end
        end else if (tx_to_s) begin
          tx_error_d = 1'b1;
          clk_oe_d   = 1'b0;
          dat_oe_d   = 1'b0;
          tx_st_d    = S_IDLE;
          tx_tmr_d   = TW'(0);
        end else begin
          tx_tmr_d = tx_tmr_q + TW'(1);
        end
      end
      default: begin
        tx_st_d  = S_IDLE;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
      end
    endcase
  end

  // Transmit state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_st_q    <= S_IDLE;
      tx_tmr_q   <= TW'(0);
      tx_bit_q   <= 4'd0;
      tx_sr_q    <= 9'h000;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_st_q    <= tx_st_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_bit_q   <= tx_bit_d;
      tx_sr_q    <= tx_sr_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
      tx_busy_q  <= (tx_st_d != S_IDLE);
    end
  end

  assign ps2clk_oe   = clk_oe_q;
  assign ps2dat_oe   = dat_oe_q;
  assign rx_data     = mem_q[rd_q][7:0];
  assign rx_extended = mem_q[rd_q][9];
  assign rx_released = mem_q[rd_q][8];
  assign rx_valid    = (cnt_q != CW'(0));
  assign rx_err      = rx_err_q;
  assign rx_overflow = ovf_q;
  assign tx_busy     = tx_busy_q;
  assign tx_done     = tx_done_q;
  assign tx_error    = tx_error_q;

endmodule
